mvu_cmd_responder: RTL and testbench

//  MVU-side endpoint of the per-hart MVU CSR/command interface driven by the pito core.
//  Per hart: snapshots the CSR job fields on that hart's mvu_start pulse and queues the job.

---
 rtl/mvu_cmd_responder_pkg.sv | 26 ++
 rtl/mvu_cmd_responder_rr_arbiter.sv | 32 +++
 rtl/mvu_cmd_responder.sv | 159 +++++++++++++++
 tb/tb_mvu_cmd_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_cmd_responder_pkg.sv
// Shared types for the MVU command responder: job record, FSM states and
// status-bit layout used by the per-hart CSR bank.
package mvu_cmd_responder_pkg;

    typedef logic [31:0] rv32_data_t;

    typedef struct packed {
        rv32_data_t cmd;
        rv32_data_t prec;
        rv32_data_t wbase;
        rv32_data_t ibase;
        rv32_data_t obase;
    } mvu_job_t;

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_ISSUE,
        RSP_RUN,
        RSP_IRQ
    } mvu_rsp_state_e;

    // Bit positions inside each hart's 2-bit status field
    localparam int MVU_STATUS_BUSY = 0;
    localparam int MVU_STATUS_ERR  = 1;

endpackage

// File: rtl/mvu_cmd_responder_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N. Returns one-hot grant, its index and an any-grant flag.
module mvu_rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    always_comb begin
        int j;
        j       = 0;
        gnt_idx = '0;
        gnt_any = |req;
        // Scan farthest-first so the nearest requester after ptr is written last
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                gnt_idx = IDX_W'(j);
            end
        end
        gnt = gnt_any ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/mvu_cmd_responder.sv
// MVU-side endpoint of the per-hart command interface: snapshots CSR jobs on
// mvu_start, round-robins them onto one job port, and raises per-hart IRQs.
module mvu_cmd_responder
    import mvu_cmd_responder_pkg::*;
#(
    parameter int NUM_HARTS = 8,
    parameter int TIMEOUT   = 65535,
    parameter int TO_W      = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_HARTS-1:0]                          mvu_start,
    input  logic [32*NUM_HARTS-1:0]                       csr_mvucommand,
    input  logic [32*NUM_HARTS-1:0]                       csr_mvuprecision,
    input  logic [32*NUM_HARTS-1:0]                       csr_mvuwbaseptr,
    input  logic [32*NUM_HARTS-1:0]                       csr_mvuibaseptr,
    input  logic [32*NUM_HARTS-1:0]                       csr_mvuobaseptr,
    output logic                                          job_valid_o,
    input  logic                                          job_ready_i,
    output logic [((NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1)-1:0] job_hart_o,
    output mvu_job_t                                      job_o,
    input  logic                                          job_done_i,
    output logic [NUM_HARTS-1:0]                          mvu_irq_o,
    output logic [2*NUM_HARTS-1:0]                        mvu_status_o
);

    localparam int IDX_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    mvu_rsp_state_e        state_reg;
    logic [NUM_HARTS-1:0]  pending_reg, pending_next;
    logic [NUM_HARTS-1:0]  err_reg, err_next;
    logic                  active_reg;
    logic [IDX_W-1:0]      owner_reg;
    logic [IDX_W-1:0]      rr_ptr_reg;
    logic [TO_W-1:0]       cnt_reg;
    logic                  valid_reg;
    logic [NUM_HARTS-1:0]  irq_reg;
    mvu_job_t              job_reg;
    mvu_job_t              snap_reg [NUM_HARTS];

    logic [NUM_HARTS-1:0]  owner_oh;
    logic [NUM_HARTS-1:0]  accept;
    logic [NUM_HARTS-1:0]  reject;
    logic [NUM_HARTS-1:0]  gnt_oh;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_any;
    logic                  grant_fire;
    logic                  timeout_hit;
    logic [IDX_W-1:0]      rr_ptr_next;

    mvu_rr_arbiter #(
        .N     (NUM_HARTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (pending_reg),
        .ptr     (rr_ptr_reg),
        .gnt     (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        owner_oh    = active_reg ? (NUM_HARTS'(1) << owner_reg) : '0;
        // A hart with a queued or in-flight job cannot take another one
        accept      = mvu_start & ~pending_reg & ~owner_oh;
        reject      = mvu_start & ~accept;
        grant_fire  = (state_reg == RSP_IDLE) && gnt_any;
        timeout_hit = (state_reg == RSP_RUN) && !job_done_i &&
                      (TIMEOUT != 0) && (cnt_reg == TO_LAST);
        rr_ptr_next = (gnt_idx == IDX_W'(NUM_HARTS - 1)) ? '0 : gnt_idx + IDX_W'(1);
        pending_next = (pending_reg & ~(grant_fire ? gnt_oh : '0)) | accept;
        err_next     = (err_reg & ~accept) | reject | (timeout_hit ? owner_oh : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
            err_reg     <= '0;
        end else begin
            pending_reg <= pending_next;
            err_reg     <= err_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_snap
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    snap_reg[gi] <= '0;
                end else if (accept[gi]) begin
                    snap_reg[gi] <= '{
                        cmd:   csr_mvucommand[32*gi +: 32],
                        prec:  csr_mvuprecision[32*gi +: 32],
                        wbase: csr_mvuwbaseptr[32*gi +: 32],
                        ibase: csr_mvuibaseptr[32*gi +: 32],
                        obase: csr_mvuobaseptr[32*gi +: 32]
                    };
                end
            end

            assign mvu_status_o[2*gi + MVU_STATUS_BUSY] = pending_reg[gi] | owner_oh[gi];
            assign mvu_status_o[2*gi + MVU_STATUS_ERR]  = err_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= RSP_IDLE;
            active_reg <= 1'b0;
            owner_reg  <= '0;
            rr_ptr_reg <= '0;
            cnt_reg    <= '0;
            valid_reg  <= 1'b0;
            irq_reg    <= '0;
            job_reg    <= '0;
        end else begin
            case (state_reg)
                RSP_IDLE: begin
                    if (gnt_any) begin
                        job_reg    <= snap_reg[gnt_idx];
                        owner_reg  <= gnt_idx;
                        active_reg <= 1'b1;
                        rr_ptr_reg <= rr_ptr_next;
                        valid_reg  <= 1'b1;
                        state_reg  <= RSP_ISSUE;
                    end
                end
                RSP_ISSUE: begin
                    if (job_ready_i) begin
                        valid_reg <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= RSP_RUN;
                    end
                end
                RSP_RUN: begin
                    cnt_reg <= cnt_reg + TO_W'(1);
                    // Completion takes priority over an expiring timeout
                    if (job_done_i || timeout_hit) begin
                        irq_reg    <= owner_oh;
                        active_reg <= 1'b0;
                        state_reg  <= RSP_IRQ;
                    end
                end
                RSP_IRQ: begin
                    irq_reg   <= '0;
                    state_reg <= RSP_IDLE;
                end
                default: state_reg <= RSP_IDLE;
            endcase
        end
    end

    assign job_valid_o = valid_reg;
    assign job_hart_o  = owner_reg;
    assign job_o       = job_reg;
    assign mvu_irq_o   = irq_reg;

endmodule

// File: tb/tb_mvu_cmd_responder.sv
// Directed bench for mvu_cmd_responder: issue order, reject/err, timeout,
// ready back-pressure and async reset, with hand-computed expectations.
module tb_mvu_cmd_responder;
    import mvu_cmd_responder_pkg::*;

    localparam int NH = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NH-1:0]   mvu_start;
    logic [32*NH-1:0] csr_cmd, csr_prec, csr_wb, csr_ib, csr_ob;
    logic            job_valid_o;
    logic            job_ready_i;
    logic [2:0]      job_hart_o;
    mvu_job_t        job_o;
    logic            job_done_i;
    logic [NH-1:0]   mvu_irq_o;
    logic [2*NH-1:0] mvu_status_o;

    logic [31:0] cmd_a [NH];
    logic [31:0] prec_a [NH];
    logic [31:0] wb_a [NH];
    logic [31:0] ib_a [NH];
    logic [31:0] ob_a [NH];

    int n_vec  = 0;
    int n_miss = 0;

    generate
        for (genvar gi = 0; gi < NH; gi++) begin : g_csr
            assign csr_cmd[32*gi +: 32]  = cmd_a[gi];
            assign csr_prec[32*gi +: 32] = prec_a[gi];
            assign csr_wb[32*gi +: 32]   = wb_a[gi];
            assign csr_ib[32*gi +: 32]   = ib_a[gi];
            assign csr_ob[32*gi +: 32]   = ob_a[gi];
        end
    endgenerate

    mvu_cmd_responder #(
        .NUM_HARTS (NH),
        .TIMEOUT   (16),
        .TO_W      (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mvu_start        (mvu_start),
        .csr_mvucommand   (csr_cmd),
        .csr_mvuprecision (csr_prec),
        .csr_mvuwbaseptr  (csr_wb),
        .csr_mvuibaseptr  (csr_ib),
        .csr_mvuobaseptr  (csr_ob),
        .job_valid_o      (job_valid_o),
        .job_ready_i      (job_ready_i),
        .job_hart_o       (job_hart_o),
        .job_o            (job_o),
        .job_done_i       (job_done_i),
        .mvu_irq_o        (mvu_irq_o),
        .mvu_status_o     (mvu_status_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic mvu_job_t mk(input int h, input logic [31:0] c, input logic [31:0] w);
        mvu_job_t j;
        j.cmd   = c;
        j.prec  = 32'h10 + 32'(h);
        j.wbase = w;
        j.ibase = 32'h200 + 32'(h);
        j.obase = 32'h300 + 32'(h);
        return j;
    endfunction

    task automatic set_csr(input int h, input logic [31:0] c, input logic [31:0] w);
        cmd_a[h]  = c;
        prec_a[h] = 32'h10 + 32'(h);
        wb_a[h]   = w;
        ib_a[h]   = 32'h200 + 32'(h);
        ob_a[h]   = 32'h300 + 32'(h);
    endtask

    task automatic pulse(input logic [NH-1:0] mask);
        mvu_start = mask;
        tick();
        mvu_start = '0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!job_valid_o && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 160'(job_valid_o), 160'(1));
    endtask

    // Wait for the offer, check it, handshake, then complete after dly RUN cycles
    task automatic serve(input int h, input mvu_job_t exp, input int dly);
        wait_valid($sformatf("h%0d", h));
        chk($sformatf("h%0d_hart", h), 160'(job_hart_o), 160'(h));
        chk($sformatf("h%0d_job", h), 160'(job_o), 160'(exp));
        job_ready_i = 1'b1;
        tick();
        job_ready_i = 1'b0;
        chk($sformatf("h%0d_run_novalid", h), 160'(job_valid_o), 160'(0));
        repeat (dly - 1) tick();
        job_done_i = 1'b1;
        tick();
        job_done_i = 1'b0;
        chk($sformatf("h%0d_irq", h), 160'(mvu_irq_o), 160'(NH'(1) << h));
        chk($sformatf("h%0d_busy_clr", h), 160'(mvu_status_o[2*h]), 160'(0));
        tick();
        chk($sformatf("h%0d_irq_pulse", h), 160'(mvu_irq_o), 160'(0));
        $display("txn hart=%0d cmd=%h wbase=%h done_after=%0d", h, exp.cmd, exp.wbase, dly);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic     bad;
        mvu_job_t exp5;

        rst_n       = 1'b0;
        mvu_start   = '0;
        job_ready_i = 1'b0;
        job_done_i  = 1'b0;
        for (int i = 0; i < NH; i++) begin
            set_csr(i, 32'h0, 32'h0);
        end
        repeat (2) tick();
        chk("rst_valid", 160'(job_valid_o), 160'(0));
        chk("rst_status", 160'(mvu_status_o), 160'(0));
        chk("rst_irq", 160'(mvu_irq_o), 160'(0));
        chk("rst_job", 160'(job_o), 160'(0));
        rst_n = 1'b1;
        tick();

        // Scenario 1: single job on hart 0, start@t -> valid@t+2
        set_csr(0, 32'hA5, 32'h100);
        pulse(8'h01);
        chk("s1_t1_novalid", 160'(job_valid_o), 160'(0));
        tick();
        chk("s1_t2_valid", 160'(job_valid_o), 160'(1));
        chk("s1_status_busy0", 160'(mvu_status_o), 160'(16'h0001));
        serve(0, mk(0, 32'hA5, 32'h100), 5);

        // Scenario 2: three simultaneous starts issue in order 1,3,6
        set_csr(1, 32'h11, 32'h1100);
        set_csr(3, 32'h33, 32'h3300);
        set_csr(6, 32'h66, 32'h6600);
        pulse(8'b0100_1010);
        chk("s2_pending", 160'(mvu_status_o & 16'h5555), 160'(16'h1044));
        serve(1, mk(1, 32'h11, 32'h1100), 2);
        serve(3, mk(3, 32'h33, 32'h3300), 3);
        serve(6, mk(6, 32'h66, 32'h6600), 1);

        // Scenario 3: repeated start on hart 2 while queued behind hart 5
        set_csr(5, 32'h55, 32'h5500);
        pulse(8'h20);
        set_csr(2, 32'h22A, 32'h2A0);
        pulse(8'h04);
        set_csr(2, 32'h22B, 32'h2B0);
        pulse(8'h04);
        chk("s3_err2", 160'(mvu_status_o[5]), 160'(1));
        chk("s3_busy2", 160'(mvu_status_o[4]), 160'(1));
        serve(5, mk(5, 32'h55, 32'h5500), 2);
        serve(2, mk(2, 32'h22A, 32'h2A0), 2);
        chk("s3_err2_sticky", 160'(mvu_status_o[5]), 160'(1));
        set_csr(2, 32'h22C, 32'h2C0);
        pulse(8'h04);
        chk("s3_err2_clr", 160'(mvu_status_o[5]), 160'(0));
        serve(2, mk(2, 32'h22C, 32'h2C0), 2);

        // Scenario 4a: timeout after 16 RUN cycles sets err[4]
        set_csr(4, 32'h44, 32'h4400);
        pulse(8'h10);
        wait_valid("s4a");
        job_ready_i = 1'b1;
        tick();
        job_ready_i = 1'b0;
        bad = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (mvu_irq_o != '0) bad = 1'b1;
        end
        chk("s4a_no_early_irq", 160'(bad), 160'(0));
        tick();
        chk("s4a_to_irq", 160'(mvu_irq_o), 160'(8'h10));
        chk("s4a_err4", 160'(mvu_status_o[9]), 160'(1));
        tick();
        $display("txn hart=4 cmd=%h timeout", 32'h44);

        // Scenario 4b: done on the 16th RUN cycle wins over timeout
        set_csr(4, 32'h45, 32'h4500);
        pulse(8'h10);
        chk("s4b_err4_clr", 160'(mvu_status_o[9]), 160'(0));
        wait_valid("s4b");
        job_ready_i = 1'b1;
        tick();
        job_ready_i = 1'b0;
        repeat (15) tick();
        job_done_i = 1'b1;
        tick();
        job_done_i = 1'b0;
        chk("s4b_irq", 160'(mvu_irq_o), 160'(8'h10));
        chk("s4b_no_err", 160'(mvu_status_o[9]), 160'(0));
        tick();
        $display("txn hart=4 cmd=%h done_on_last_cycle", 32'h45);

        // Scenario 5: ready held low 10 cycles, done during ISSUE ignored
        set_csr(7, 32'h77, 32'h7700);
        exp5 = mk(7, 32'h77, 32'h7700);
        pulse(8'h80);
        wait_valid("s5");
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!job_valid_o || job_o !== exp5 || job_hart_o !== 3'd7 || mvu_irq_o != '0) bad = 1'b1;
            job_done_i = (i == 3);
            tick();
        end
        job_done_i = 1'b0;
        chk("s5_stable", 160'(bad), 160'(0));
        serve(7, exp5, 3);

        // Scenario 6: async reset while RUN clears everything at once
        set_csr(3, 32'h3C, 32'h3C00);
        pulse(8'h08);
        wait_valid("s6");
        job_ready_i = 1'b1;
        tick();
        job_ready_i = 1'b0;
        tick();
        chk("s6_busy_pre", 160'(mvu_status_o[6]), 160'(1));
        rst_n = 1'b0;
        #1;
        chk("s6_rst_status", 160'(mvu_status_o), 160'(0));
        chk("s6_rst_hart", 160'(job_hart_o), 160'(0));
        chk("s6_rst_job", 160'(job_o), 160'(0));
        chk("s6_rst_valid_irq", 160'({job_valid_o, mvu_irq_o}), 160'(0));
        tick();
        rst_n = 1'b1;
        tick();
        set_csr(0, 32'hA5, 32'h100);
        pulse(8'h01);
        chk("s6_t1_novalid", 160'(job_valid_o), 160'(0));
        tick();
        chk("s6_t2_valid", 160'(job_valid_o), 160'(1));
        serve(0, mk(0, 32'hA5, 32'h100), 5);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
